regfile_wr_arbiter: RTL

//   Shares the single register-file write port (wena/waddr/wdata) among NUM_REQ writeback sources
//   (e.g. ALU writeback, load writeback, debug loader).
//   - Round-robin arbitration with a valid/ready handshake per requester.
//   - Optional lock, so one source can own the port for a burst.
//   - Registered outputs drive the register file write port directly.

---
 rtl/mini_proc_pkg.sv | 15 +
 rtl/regfile_wr_arbiter_if.sv | 33 +++
 rtl/regfile_wr_arbiter_picker.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mini_proc_pkg.sv
// Shared types and defaults for the register-file writeback path.
package mini_proc_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } rf_arb_state_t;

  // Register 0 is architecturally hardwired in some cores; see REG0_GUARD_EN.
  localparam logic [DEF_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester handshake bus plus the register-file write port it feeds.
// slave = arbiter side, master = requesters / register-file side.
interface regfile_wr_arbiter_if
  import mini_proc_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rf_wena;
  logic [ADDR_WIDTH-1:0]         rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic [IW-1:0]                 grant_id;
  logic                          locked;

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, rf_wena, rf_waddr, rf_wdata, grant_id, locked
  );

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, rf_wena, rf_waddr, rf_wdata, grant_id, locked
  );

endinterface

// File: rtl/regfile_wr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick. Scans ptr, ptr+1, ...
// modulo N and returns the first requesting index as one-hot and binary.
module rr_priority_picker #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  int            w_j;
  logic [IW-1:0] w_jj;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = 0;
    w_jj  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_jj = IW'(w_j);
      if (i_req[w_jj]) begin
        o_gnt       = '0;
        o_gnt[w_jj] = 1'b1;
        o_idx       = w_jj;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single register-file write port among
// NUM_REQ writeback sources with round-robin arbitration and an optional
// per-source lock for bursts. Write port outputs are registered.
// Build option: define REG0_GUARD_EN to suppress writes to register 0
// (the handshake still completes, only rf_wena is held low).
module regfile_wr_arbiter
  import mini_proc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = 3
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);

  rf_arb_state_t          r_state;
  logic [IW-1:0]          r_ptr;
  logic [IW-1:0]          r_owner;
  logic                   r_wena;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [IW-1:0]          r_gid;

  logic [NUM_REQ-1:0]                 w_pick_gnt;
  logic [IW-1:0]                      w_pick_idx;
  logic [NUM_REQ-1:0]                 w_ready;
  logic [IW-1:0]                      w_win;
  logic                               w_hs;
  logic                               w_wr_en;
  logic [IW-1:0]                      w_ptr_nxt;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] w_addr_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_data_arr;
  logic [ADDR_WIDTH-1:0]              w_addr;
  logic [DATA_WIDTH-1:0]              w_data;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // While locked the picker result is ignored: only the owner may be ready.
  always_comb begin
    w_ready = '0;
    w_win   = w_pick_idx;
    if (r_state == LOCKED) begin
      w_win = r_owner;
      if (bus.req_valid[r_owner]) w_ready[r_owner] = 1'b1;
    end else begin
      w_ready = w_pick_gnt;
    end
  end

  assign w_hs       = |(w_ready & bus.req_valid);
  assign w_addr_arr = bus.req_addr;
  assign w_data_arr = bus.req_data;
  assign w_addr     = w_addr_arr[w_win];
  assign w_data     = w_data_arr[w_win];
  assign w_ptr_nxt  = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

`ifdef REG0_GUARD_EN
  assign w_wr_en = w_hs & (w_addr != ADDR_WIDTH'(REG_ZERO));
`else
  assign w_wr_en = w_hs;
`endif

  // Arbitration state: pointer advances only on ARB handshakes; lock entry/exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_hs) begin
            r_ptr <= w_ptr_nxt;
            if (bus.req_lock[w_win]) begin
              r_state <= LOCKED;
              r_owner <= w_win;
            end
          end
        end
        LOCKED: begin
          // Exit as soon as the owner drops lock, whether or not it wrote.
          if (!bus.req_lock[r_owner]) r_state <= ARB;
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // Registered write port: wena pulses per handshake, addr/data/grant hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wena  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_gid   <= '0;
    end else begin
      r_wena <= w_wr_en;
      if (w_hs) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
        r_gid   <= w_win;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rf_wena   = r_wena;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.grant_id  = r_gid;
  assign bus.locked    = (r_state == LOCKED);

endmodule
